// File: rtl/vga_pkg.sv
// Shared VGA/framebuffer definitions: default 640x480 timing, scan state, color and address helpers.
package vga_pkg;

  localparam int unsigned DefHActive = 640;
  localparam int unsigned DefHFp     = 16;
  localparam int unsigned DefHSync   = 96;
  localparam int unsigned DefHBp     = 48;
  localparam int unsigned DefVActive = 480;
  localparam int unsigned DefVFp     = 10;
  localparam int unsigned DefVSync   = 2;
  localparam int unsigned DefVBp     = 33;

  typedef enum logic {StIdle, StRun} scan_state_e;

  function automatic logic [3:0] col_r(input logic [11:0] c);
    return c[11:8];
  endfunction

  function automatic logic [3:0] col_g(input logic [11:0] c);
    return c[7:4];
  endfunction

  function automatic logic [3:0] col_b(input logic [11:0] c);
    return c[3:0];
  endfunction

  // Framebuffer address layout, shared with the pixel writers.
  function automatic logic [15:0] pix_addr(input logic [7:0] x, input logic [7:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Frame counters, RUN/IDLE control and stage-0 sync/active/image-window decode.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned X_OFF    = 192,
  parameter int unsigned Y_OFF    = 112,
  localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_enable,
  output logic [HW-1:0] o_h_cnt,
  output logic [VW-1:0] o_v_cnt,
  output logic          o_run,
  output logic          o_active,
  output logic          o_in_img,
  output logic          o_hs_n,
  output logic          o_vs_n,
  output logic          o_first,
  output logic          o_stop
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [HW-1:0] HLast = HW'(HTotal - 1);
  localparam logic [VW-1:0] VLast = VW'(VTotal - 1);

  scan_state_e   r_state;
  logic [HW-1:0] r_h;
  logic [VW-1:0] r_v;
  logic          w_run;
  logic          w_last;
  logic          w_active;
  logic [31:0]   w_h;
  logic [31:0]   w_v;

  assign w_run  = (r_state == StRun);
  assign w_last = (r_h == HLast) && (r_v == VLast);
  assign w_h    = 32'(r_h);
  assign w_v    = 32'(r_v);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_h     <= '0;
      r_v     <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_h <= '0;
          r_v <= '0;
          if (i_enable) r_state <= StRun;
        end
        StRun: begin
          if (r_h == HLast) begin
            r_h <= '0;
            if (r_v == VLast) begin
              r_v <= '0;
              if (!i_enable) r_state <= StIdle;
            end else begin
              r_v <= r_v + 1'b1;
            end
          end else begin
            r_h <= r_h + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Every decode is gated by RUN so IDLE (counters parked at 0) reads as blanking.
  assign w_active = w_run && (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
  assign o_active = w_active;
  assign o_in_img = w_active && (w_h >= X_OFF) && (w_h < X_OFF + IMG_W)
                    && (w_v >= Y_OFF) && (w_v < Y_OFF + IMG_H);
  assign o_hs_n   = !(w_run && (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC));
  assign o_vs_n   = !(w_run && (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC));
  assign o_first  = w_run && (r_h == '0) && (r_v == '0);
  assign o_stop   = w_run && w_last && !i_enable;
  assign o_run    = w_run;
  assign o_h_cnt  = r_h;
  assign o_v_cnt  = r_v;

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scan-out: address generation plus a 2-stage pipeline aligning color with sync.
module vga_fb_scanout
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DefHActive,
  parameter int unsigned H_FP     = DefHFp,
  parameter int unsigned H_SYNC   = DefHSync,
  parameter int unsigned H_BP     = DefHBp,
  parameter int unsigned V_ACTIVE = DefVActive,
  parameter int unsigned V_FP     = DefVFp,
  parameter int unsigned V_SYNC   = DefVSync,
  parameter int unsigned V_BP     = DefVBp,
  parameter int unsigned IMG_W    = 256,
  parameter int unsigned IMG_H    = 256,
  parameter int unsigned X_OFF    = 192,
  parameter int unsigned Y_OFF    = 112,
  parameter logic [11:0] BORDER   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  input  logic [11:0] rd_data,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start,
  output logic        frame_done
);

  localparam int unsigned HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int unsigned VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [HW-1:0] w_h_cnt;
  logic [VW-1:0] w_v_cnt;
  logic          w_run;
  logic          w_active;
  logic          w_in_img;
  logic          w_hs_n;
  logic          w_vs_n;
  logic          w_first;
  logic          w_stop;
  logic [7:0]    w_x;
  logic [7:0]    w_y;
  logic [11:0]   w_color;

  logic          r_act1, r_img1, r_hs1, r_vs1, r_fs1, r_fd1;
  logic          r_de, r_hs, r_vs, r_fs, r_fd;
  logic [11:0]   r_rgb;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .X_OFF    (X_OFF),
    .Y_OFF    (Y_OFF)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .i_enable (enable),
    .o_h_cnt  (w_h_cnt),
    .o_v_cnt  (w_v_cnt),
    .o_run    (w_run),
    .o_active (w_active),
    .o_in_img (w_in_img),
    .o_hs_n   (w_hs_n),
    .o_vs_n   (w_vs_n),
    .o_first  (w_first),
    .o_stop   (w_stop)
  );

  assign w_x     = 8'(32'(w_h_cnt) - X_OFF);
  assign w_y     = 8'(32'(w_v_cnt) - Y_OFF);
  assign rd_en   = w_in_img && w_run;
  assign rd_addr = rd_en ? pix_addr(w_x, w_y) : 16'h0000;

  // Stage 1 holds the decode while the framebuffer read completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_act1 <= 1'b0;
      r_img1 <= 1'b0;
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_fs1  <= 1'b0;
      r_fd1  <= 1'b0;
    end else begin
      r_act1 <= w_active;
      r_img1 <= w_in_img;
      r_hs1  <= w_hs_n;
      r_vs1  <= w_vs_n;
      r_fs1  <= w_first;
      r_fd1  <= w_stop;
    end
  end

  always_comb begin
    w_color = 12'h000;
    if (r_img1)      w_color = rd_data;
    else if (r_act1) w_color = BORDER;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_de  <= 1'b0;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_fs  <= 1'b0;
      r_fd  <= 1'b0;
      r_rgb <= 12'h000;
    end else begin
      r_de  <= r_act1;
      r_hs  <= r_hs1;
      r_vs  <= r_vs1;
      r_fs  <= r_fs1;
      r_fd  <= r_fd1;
      r_rgb <= w_color;
    end
  end

  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign de          = r_de;
  assign red         = col_r(r_rgb);
  assign green       = col_g(r_rgb);
  assign blue        = col_b(r_rgb);
  assign frame_start = r_fs;
  assign frame_done  = r_fd;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed bench for vga_fb_scanout on a 14x7 raster with a 4x2 image window.
module tb_vga_fb_scanout;

  localparam int Tot = 98;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [11:0] rd_data;
  logic        hsync, vsync, de;
  logic [3:0]  red, green, blue;
  logic        frame_start, frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Framebuffer model: one-clock read latency, data derived from the address.
  always @(posedge clk) begin
    if (rd_en) rd_data <= {rd_addr[15:8], rd_addr[3:0]};
  end

  vga_fb_scanout #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (2),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .IMG_W    (4),
    .IMG_H    (2),
    .X_OFF    (2),
    .Y_OFF    (1),
    .BORDER   (12'hF00)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .frame_start (frame_start),
    .frame_done  (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_hsync"}, hsync, 1);
    chk({tag, "_vsync"}, vsync, 1);
    chk({tag, "_de"}, de, 0);
    chk({tag, "_rgb"}, {red, green, blue}, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_fs"}, frame_start, 0);
    chk({tag, "_fd"}, frame_done, 0);
  endtask

  // Expected pins {hsync, vsync, de, rgb} for output pixel index p of a run of 'total' pixels.
  function automatic logic [14:0] exp_pins(input int p, input int total);
    int pos, h, v;
    logic d;
    logic [11:0] rgb;
    logic [7:0] yy;
    logic [3:0] xx;
    if (p < 0 || p >= total) return {1'b1, 1'b1, 1'b0, 12'h000};
    pos = p % Tot;
    h   = pos % 14;
    v   = pos / 14;
    d   = (h < 8) && (v < 4);
    yy  = 8'(v - 1);
    xx  = 4'(h - 2);
    if (d && h >= 2 && h < 6 && v >= 1 && v < 3) rgb = {yy, xx};
    else if (d) rgb = 12'hF00;
    else rgb = 12'h000;
    return {!(h == 10 || h == 11), v != 5, d, rgb};
  endfunction

  // Entered at the negedge where the counters read (0,0); k indexes counter values.
  task automatic scan(input int nfr, input int drop_k, input bit restart);
    int total, last_k, nfs, nfd, kfs, kfd, p, pos, h, v, ea;
    logic [14:0] e;
    bit img;
    total  = nfr * Tot;
    last_k = restart ? total + 1 : total + 4;
    nfs = 0; nfd = 0; kfs = 0; kfd = 0;
    for (int k = 0; k <= last_k; k++) begin
      p = k - 2;
      e = exp_pins(p, total);
      chk("hsync", hsync, e[14]);
      chk("vsync", vsync, e[13]);
      chk("de", de, e[12]);
      chk("rgb", {red, green, blue}, e[11:0]);
      chk("frame_start", frame_start, (p >= 0 && p < total && p % Tot == 0));
      chk("frame_done", frame_done, (p == total - 1));
      img = 0; ea = 0;
      if (k < total) begin
        pos = k % Tot; h = pos % 14; v = pos / 14;
        img = (h >= 2 && h < 6 && v >= 1 && v < 3);
        if (img) ea = (v - 1) * 256 + (h - 2);
      end
      chk("rd_en", rd_en, img);
      chk("rd_addr", rd_addr, ea);
      if (p == 31) chk("pix_h3_v2", {red, green, blue}, 32'h011);
      if (p == 14) chk("pix_h0_v1", {red, green, blue}, 32'hF00);
      if (frame_start) begin nfs++; kfs = k; end
      if (frame_done) begin nfd++; kfd = k; end
      if (k == drop_k) enable = 1'b0;
      if (restart && k == total + 1) enable = 1'b1;
      tick();
    end
    chk("fs_count", nfs, nfr);
    chk("fd_count", nfd, 1);
    chk("fs_to_fd", kfd - kfs, 97);
  endtask

  initial begin
    reset  = 1'b0;
    enable = 1'b0;
    repeat (2) tick();
    chk_idle("rst");
    reset = 1'b1;
    repeat (5) tick();
    chk_idle("post_rst");

    // Reset asserted mid-frame while inside the image window.
    enable = 1'b1;
    tick();
    enable = 1'b0;
    repeat (17) tick();
    chk("pre_rst_de", de, 1);
    chk("pre_rst_rgb", {red, green, blue}, 32'hF00);
    chk("pre_rst_rd_en", rd_en, 1);
    #2 reset = 1'b0;
    #1 chk_idle("async_rst");
    repeat (2) tick();
    reset = 1'b1;
    repeat (5) tick();
    chk_idle("after_rst");

    // Single frame from a one-clock enable pulse.
    enable = 1'b1;
    tick();
    scan(1, 0, 1'b0);
    chk_idle("single_end");

    // Three back-to-back frames, stop during line 2 of the third, restart on frame_done.
    enable = 1'b1;
    tick();
    scan(3, 2 * Tot + 31, 1'b1);
    scan(1, 0, 1'b0);
    chk_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
